lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised Fibonacci linear-feedback shift register: the general-purpose successor to the team's fixed 3-bit structural LFSR. It adds configurable width and tap polynomial, runtime seed load, step enable, zero-seed protection and on-line period measurement. It sits in test-pattern and scrambler paths as a pseudo-random source. Software and the bench can confirm a tap set is maximal-length from the measured period.

## Interface
- WIDTH, 8: register width; legal range 3..32.
- TAPS, 8'hB8: feedback mask, WIDTH bits; bit i set means q[i] enters the feedback XOR; bit WIDTH-1 must be set.
- SEED, 8'h01: reset and fallback seed, WIDTH bits, must be non-zero.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance the register one step this cycle.
- load  in  1  load seed_in this cycle; has priority over en.
- seed_in  in  WIDTH  runtime seed.
- q  out  WIDTH  current register state.
- serial_out  out  1  q[WIDTH-1], the bit shifted out.
- wrap  out  1  one-cycle pulse when a step returns the state to the active seed.
- count  out  WIDTH  steps taken since the last load, reset or wrap.
- period  out  WIDTH  step count of the last completed cycle, latched at wrap.
- period_valid  out  1  set at first wrap, cleared by load or reset.

## Operation
- Registers:
  - state (drives q).
  - seed_r: the active seed.
  - count.
  - period.
  - period_valid.
  - wrap.
- Feedback: fb = XOR-reduce(state & TAPS).
- Step: state <= {state[WIDTH-2:0], fb}.
- Reset (async, rst=1): state = SEED, seed_r = SEED, count = 0, period = 0, period_valid = 0, wrap = 0. serial_out follows q.
- Priority per cycle: load, then en, then hold.
- load=1:
  - Effective seed s = seed_in, or SEED if seed_in is all-zero.
  - state <= s, seed_r <= s, count <= 0, period_valid <= 0, wrap <= 0.
  - period holds its old value and is not valid.
- en=1, load=0:
  - Perform a step.
  - If the next state equals seed_r: wrap <= 1, period <= count+1, period_valid <= 1, count <= 0.
  - Otherwise: count <= count+1, modulo 2^WIDTH, wrap <= 0.
- en=0, load=0: all registers hold, and wrap <= 0.
- Lockup guard: if state is ever all-zero (for example after an SEU) and en=1, the next state is seed_r, treated as a wrap.
  - This is the only non-XOR transition.
- Arithmetic: count and period are unsigned WIDTH bits. A maximal sequence has period 2^WIDTH-1, so it always fits. Count overflow wraps silently; this only happens with a non-maximal TAPS that never returns to the seed.

## Timing
- Latency: q reflects load or step one clock after the sampling edge. There are no combinational paths from inputs to outputs.
- wrap is registered. It is high for exactly the one cycle in which q equals seed_r after a step. Back-to-back wraps are possible only for period 1.
- en can be held continuously (one step per cycle) or gapped arbitrarily; gaps change no values.
- If load and en are both high in the same cycle, the load is taken and no step occurs.
- If reset asserts mid-run, outputs go to reset values immediately, without waiting for a clock edge. On release, stepping resumes from SEED on the first edge with en=1.

## Test plan
- Reset, then en=1 with WIDTH=8, TAPS=B8, SEED=01 -> q sequence 01, 02, 04, 08, 11, 23 on successive cycles. wrap=0 throughout.
- Free-run from reset for 255 enabled cycles -> wrap pulses once on step 255 with q=01, period=255, period_valid=1, count=0.
- load=1 with seed_in=00 -> q=01, seed_r=01, period_valid=0. Then load with seed_in=5A -> q=5A; after 255 steps wrap fires with q=5A.
- load and en both high while q=23, seed_in=80 -> q=80 next cycle, count=0, no step.
- en toggled 1,0,0,1 from q=01 -> q goes 02, 02, 02, 04. count goes 1, 1, 1, 2. No wrap.
- Assert rst asynchronously mid-run at q=23 -> q=01 and count=0 before the next edge. Force state to 00 via the bench, then en=1 -> q=seed_r and wrap=1.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with runtime seed load, step enable,
// zero-seed protection, lockup recovery and on-line period measurement.
//
// Parameters
//   WIDTH  register width (3..32)
//   TAPS   feedback mask; bit i set means q[i] enters the feedback XOR.
//          Bit WIDTH-1 must be set.
//   SEED   reset and fallback seed; must be non-zero.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   en            in   advance the register one step this cycle
//   load          in   load seed_in this cycle (priority over en)
//   seed_in       in   runtime seed; all-zero selects SEED instead
//   q             out  current register state
//   serial_out    out  q[WIDTH-1], the bit shifted out
//   wrap          out  one-cycle pulse when a step lands on the active seed
//   count         out  steps since the last load, reset or wrap
//   period        out  step count of the last completed cycle
//   period_valid  out  set at the first wrap, cleared by load or reset
//
// Control handshake: there is no back-pressure. load and en are sampled on
// every rising edge; load wins over en, and with neither asserted every
// register holds. All outputs come straight from flops.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             wrap_q, wrap_d;

  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_step;
  logic [WIDTH-1:0] load_seed;
  logic [WIDTH-1:0] count_inc;

  always_comb begin
    fb        = ^(state_q & TAPS);
    shifted   = {state_q[WIDTH-2:0], fb};
    // An all-zero state is a fixed point of the XOR feedback; jump back to
    // the active seed instead. Because the target equals seed_q, the wrap
    // path below treats it as a completed cycle automatically.
    next_step = (state_q == '0) ? seed_q : shifted;
    load_seed = (seed_in == '0) ? SEED : seed_in;
    count_inc = count_q + ONE;
  end

  always_comb begin
    state_d        = state_q;
    seed_d         = seed_q;
    count_d        = count_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    wrap_d         = 1'b0;

    if (load) begin
      // period keeps its last value but is flagged stale.
      state_d        = load_seed;
      seed_d         = load_seed;
      count_d        = '0;
      period_valid_d = 1'b0;
    end else if (en) begin
      state_d = next_step;
      if (next_step == seed_q) begin
        wrap_d         = 1'b1;
        period_d       = count_inc;
        period_valid_d = 1'b1;
        count_d        = '0;
      end else begin
        // Silently wraps modulo 2^WIDTH for taps that never revisit the seed.
        count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= SEED;
      seed_q         <= SEED;
      count_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      seed_q         <= seed_d;
      count_q        <= count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      wrap_q         <= wrap_d;
    end
  end

  assign q            = state_q;
  assign serial_out   = state_q[WIDTH-1];
  assign wrap         = wrap_q;
  assign count        = count_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Testbench for lfsr_gen (WIDTH=8, TAPS=B8, SEED=01).
// Inputs are driven on the falling edge and outputs checked on the next
// falling edge, half a period after the rising edge that updated them.
module tb_lfsr_gen;

  localparam int         W    = 8;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] seed_in = '0;
  logic [W-1:0] q;
  logic         serial_out;
  logic         wrap;
  logic [W-1:0] count;
  logic [W-1:0] period;
  logic         period_valid;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .load         (load),
    .seed_in      (seed_in),
    .q            (q),
    .serial_out   (serial_out),
    .wrap         (wrap),
    .count        (count),
    .period       (period),
    .period_valid (period_valid)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Integer view of the register: step = shift left, append parity of tapped
  // bits, keep the low 8 bits. Tracks the seed, counts and wrap flag.
  int m_state, m_seed, m_count, m_period;
  bit m_pv, m_wrap;

  function automatic void model_reset();
    m_state = SEED; m_seed = SEED; m_count = 0; m_period = 0; m_pv = 0; m_wrap = 0;
  endfunction

  function automatic void model_cycle(input bit ld, input bit e, input int sin);
    int nxt;
    if (ld) begin
      m_state = (sin == 0) ? int'(SEED) : sin;
      m_seed  = m_state;
      m_count = 0;
      m_pv    = 0;
      m_wrap  = 0;
    end else if (e) begin
      if (m_state == 0) nxt = m_seed;
      else nxt = ((m_state * 2) + ($countones(m_state & int'(TAPS)) % 2)) % 256;
      m_state = nxt;
      if (nxt == m_seed) begin
        m_wrap = 1; m_period = m_count + 1; m_pv = 1; m_count = 0;
      end else begin
        m_wrap = 0; m_count = (m_count + 1) % 256;
      end
    end else begin
      m_wrap = 0;
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".q"},            32'(q),            32'(m_state));
    check({tag, ".serial_out"},   32'(serial_out),   32'(m_state / 128));
    check({tag, ".count"},        32'(count),        32'(m_count));
    check({tag, ".period"},       32'(period),       32'(m_period));
    check({tag, ".period_valid"}, 32'(period_valid), 32'(m_pv));
    check({tag, ".wrap"},         32'(wrap),         32'(m_wrap));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit ld, input bit e, input logic [W-1:0] sin);
    load = ld; en = e; seed_in = sin;
    @(negedge clk);
    model_cycle(ld, e, int'(sin));
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 0; en = 0; seed_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         ld;
    bit         e;
    logic [7:0] sin;
    logic [7:0] exp_q;
    logic [7:0] exp_count;
    bit         exp_wrap;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int wraps_seen;
    int wrap_step;

    // From reset: 01 -> 02 -> 04 -> 08 -> 11 -> 23
    vecs[0]  = '{0, 1, 8'h00, 8'h02, 8'd1, 0};
    vecs[1]  = '{0, 1, 8'h00, 8'h04, 8'd2, 0};
    vecs[2]  = '{0, 1, 8'h00, 8'h08, 8'd3, 0};
    vecs[3]  = '{0, 1, 8'h00, 8'h11, 8'd4, 0};
    vecs[4]  = '{0, 1, 8'h00, 8'h23, 8'd5, 0};
    // load and en together at q=23: load wins, no step
    vecs[5]  = '{1, 1, 8'h80, 8'h80, 8'd0, 0};
    vecs[6]  = '{0, 0, 8'h00, 8'h80, 8'd0, 0};
    // zero seed falls back to SEED
    vecs[7]  = '{1, 0, 8'h00, 8'h01, 8'd0, 0};
    // en gapped 1,0,0,1
    vecs[8]  = '{0, 1, 8'h00, 8'h02, 8'd1, 0};
    vecs[9]  = '{0, 0, 8'h00, 8'h02, 8'd1, 0};
    vecs[10] = '{0, 0, 8'h00, 8'h02, 8'd1, 0};
    vecs[11] = '{0, 1, 8'h00, 8'h04, 8'd2, 0};

    // ---- reset state ----
    rst = 1'b1;
    @(negedge clk);
    check("rst.q", 32'(q), 32'h01);
    check("rst.count", 32'(count), 32'h0);
    check("rst.period", 32'(period), 32'h0);
    check("rst.period_valid", 32'(period_valid), 32'h0);
    check("rst.wrap", 32'(wrap), 32'h0);
    check("rst.serial_out", 32'(serial_out), 32'h0);
    rst = 1'b0;

    // ---- table vectors ----
    foreach (vecs[i]) begin
      load = vecs[i].ld; en = vecs[i].e; seed_in = vecs[i].sin;
      @(negedge clk);
      check($sformatf("vec%0d.q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end
    check("vec.period_valid_after_load", 32'(period_valid), 32'h0);

    // ---- free run of 255 steps from reset ----
    do_reset();
    wraps_seen = 0;
    wrap_step  = 0;
    for (int i = 1; i <= 255; i++) begin
      drive(0, 1, 8'h00);
      check_model($sformatf("run%0d", i));
      if (wrap === 1'b1) begin
        wraps_seen++;
        wrap_step = i;
      end
    end
    check("run.wraps_seen", 32'(wraps_seen), 32'd1);
    check("run.wrap_step", 32'(wrap_step), 32'd255);
    check("run.q_at_wrap", 32'(q), 32'h01);
    check("run.period", 32'(period), 32'd255);
    check("run.period_valid", 32'(period_valid), 32'd1);
    check("run.count", 32'(count), 32'd0);
    drive(0, 0, 8'h00);
    check("run.wrap_one_cycle", 32'(wrap), 32'd0);

    // ---- zero-seed load then seed 5A full cycle ----
    drive(1, 0, 8'h00);
    check("ld0.q", 32'(q), 32'h01);
    check("ld0.period_valid", 32'(period_valid), 32'd0);
    check("ld0.period_held", 32'(period), 32'd255);
    drive(1, 0, 8'h5A);
    check("ld5a.q", 32'(q), 32'h5A);
    wraps_seen = 0;
    wrap_step  = 0;
    for (int i = 1; i <= 255; i++) begin
      drive(0, 1, 8'h00);
      check_model($sformatf("s5a_%0d", i));
      if (wrap === 1'b1) begin
        wraps_seen++;
        wrap_step = i;
      end
    end
    check("s5a.wraps_seen", 32'(wraps_seen), 32'd1);
    check("s5a.wrap_step", 32'(wrap_step), 32'd255);
    check("s5a.q_at_wrap", 32'(q), 32'h5A);
    check("s5a.period", 32'(period), 32'd255);

    // ---- randomized stimulus against the model ----
    for (int i = 0; i < 3000; i++) begin
      bit         r_ld;
      bit         r_en;
      logic [7:0] r_sin;
      r_ld  = ($urandom_range(0, 39) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_sin = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      drive(r_ld, r_en, r_sin);
      check_model($sformatf("rnd%0d", i));
    end

    // ---- asynchronous reset mid-run at q=23 ----
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 1, 8'h00);
    check("arst.pre_q", 32'(q), 32'h23);
    #2;
    rst = 1'b1;
    #1;
    check("arst.q_before_edge", 32'(q), 32'h01);
    check("arst.count_before_edge", 32'(count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(0, 1, 8'h00);
    check("arst.resume_q", 32'(q), 32'h02);

    // ---- lockup guard: force state to zero ----
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h00);
    check("lock.pre_count", 32'(count), 32'd3);
    force dut.state_q = '0;
    #1;
    release dut.state_q;
    #1;
    check("lock.forced_q", 32'(q), 32'h00);
    load = 0; en = 1; seed_in = '0;
    @(negedge clk);
    check("lock.q", 32'(q), 32'h01);
    check("lock.wrap", 32'(wrap), 32'd1);
    check("lock.period", 32'(period), 32'd4);
    check("lock.period_valid", 32'(period_valid), 32'd1);
    check("lock.count", 32'(count), 32'd0);
    en = 0;
    @(negedge clk);
    check("lock.wrap_drop", 32'(wrap), 32'd0);

    // ---- final report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
